// File: rtl/lif_pkg.sv
// Shared constants for the configurable LIF neuron: config map, reset defaults
// and the post-spike membrane reset mode.
package lif_pkg;

  localparam logic [3:0] ADDR_SHIFT  = 4'd8;
  localparam logic [3:0] ADDR_THETA  = 4'd9;
  localparam logic [3:0] ADDR_REFRAC = 4'd10;
  localparam logic [3:0] ADDR_MODE   = 4'd11;

  localparam int W_DEF     = 1;
  localparam int SHIFT_DEF = 1;
  localparam int THETA_DEF = 5;

  typedef enum logic {
    RST_ZERO = 1'b0,
    RST_SUB  = 1'b1
  } reset_mode_e;

endpackage

// File: rtl/lif_accumulate.sv
// Combinational leak + weighted input sum + saturating clamp, with threshold
// compare producing the fire flag.
module lif_accumulate
  import lif_pkg::*;
#(
  parameter int N_INPUTS = 4,
  parameter int U_WIDTH  = 8,
  parameter int W_WIDTH  = 4
) (
  input  logic [U_WIDTH-1:0]                u_i,
  input  logic [N_INPUTS-1:0]               x_i,
  input  logic [N_INPUTS-1:0][W_WIDTH-1:0]  weight_i,
  input  logic [2:0]                        shift_i,
  input  logic [U_WIDTH-1:0]                theta_i,
  output logic [U_WIDTH-1:0]                sum_o,
  output logic                              fire_o
);

  localparam int SW = U_WIDTH + 4;

  logic [U_WIDTH-1:0]  ul;
  logic signed [SW-1:0] acc;

  always_comb begin
    ul  = (shift_i == 3'd0) ? u_i : u_i - (u_i >> shift_i);
    acc = $signed({4'b0000, ul});
    for (int i = 0; i < N_INPUTS; i++) begin
      if (x_i[i]) begin
        acc = acc + $signed({{(SW-W_WIDTH){weight_i[i][W_WIDTH-1]}}, weight_i[i]});
      end
    end
    // Four guard bits cover the worst-case overshoot in either direction.
    if (acc[SW-1]) begin
      sum_o = '0;
    end else if (acc[SW-2:U_WIDTH] != '0) begin
      sum_o = '1;
    end else begin
      sum_o = acc[U_WIDTH-1:0];
    end
    fire_o = (sum_o >= theta_i);
  end

endmodule

// File: rtl/lif_neuron_cfg.sv
// Single leaky integrate-and-fire neuron with N binary synapses, register-port
// configuration and a refractory down-counter; integrates only on step.
module lif_neuron_cfg
  import lif_pkg::*;
#(
  parameter int N_INPUTS     = 4,
  parameter int U_WIDTH      = 8,
  parameter int W_WIDTH      = 4,
  parameter int REFRAC_WIDTH = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                step,
  input  logic [N_INPUTS-1:0] x_in,
  input  logic                cfg_we,
  input  logic [3:0]          cfg_addr,
  input  logic [7:0]          cfg_data,
  output logic                spike,
  output logic [U_WIDTH-1:0]  u_out,
  output logic                refractory,
  output logic [7:0]          spike_count
);

  logic [U_WIDTH-1:0]               u_q, u_d;
  logic                             spike_q, spike_d;
  logic [REFRAC_WIDTH-1:0]          rcnt_q, rcnt_d;
  logic [7:0]                       cnt_q, cnt_d;
  logic [N_INPUTS-1:0][W_WIDTH-1:0] weight_q, weight_d;
  logic [2:0]                       shift_q, shift_d;
  logic [U_WIDTH-1:0]               theta_q, theta_d;
  logic [REFRAC_WIDTH-1:0]          refrac_q, refrac_d;
  reset_mode_e                      mode_q, mode_d;

  logic [U_WIDTH-1:0] sum;
  logic               fire;

  lif_accumulate #(
    .N_INPUTS (N_INPUTS),
    .U_WIDTH  (U_WIDTH),
    .W_WIDTH  (W_WIDTH)
  ) u_acc (
    .u_i      (u_q),
    .x_i      (x_in),
    .weight_i (weight_q),
    .shift_i  (shift_q),
    .theta_i  (theta_q),
    .sum_o    (sum),
    .fire_o   (fire)
  );

  always_comb begin
    u_d      = u_q;
    spike_d  = 1'b0;
    rcnt_d   = rcnt_q;
    cnt_d    = cnt_q;
    weight_d = weight_q;
    shift_d  = shift_q;
    theta_d  = theta_q;
    refrac_d = refrac_q;
    mode_d   = mode_q;

    if (step) begin
      if (rcnt_q != '0) begin
        rcnt_d = rcnt_q - REFRAC_WIDTH'(1);
        u_d    = '0;
      end else if (fire) begin
        spike_d = 1'b1;
        u_d     = (mode_q == RST_SUB) ? sum - theta_q : '0;
        rcnt_d  = refrac_q;
        cnt_d   = cnt_q + 8'd1;
      end else begin
        u_d = sum;
      end
    end

    // Config lands in _d so a same-cycle step still sees the old value.
    if (cfg_we) begin
      for (int i = 0; i < N_INPUTS; i++) begin
        if (cfg_addr == 4'(i)) weight_d[i] = cfg_data[W_WIDTH-1:0];
      end
      case (cfg_addr)
        ADDR_SHIFT:  shift_d  = cfg_data[2:0];
        ADDR_THETA:  theta_d  = U_WIDTH'(cfg_data);
        ADDR_REFRAC: refrac_d = cfg_data[REFRAC_WIDTH-1:0];
        ADDR_MODE:   mode_d   = reset_mode_e'(cfg_data[0]);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      u_q      <= '0;
      spike_q  <= 1'b0;
      rcnt_q   <= '0;
      cnt_q    <= '0;
      weight_q <= {N_INPUTS{W_WIDTH'(W_DEF)}};
      shift_q  <= 3'(SHIFT_DEF);
      theta_q  <= U_WIDTH'(THETA_DEF);
      refrac_q <= '0;
      mode_q   <= RST_ZERO;
    end else begin
      u_q      <= u_d;
      spike_q  <= spike_d;
      rcnt_q   <= rcnt_d;
      cnt_q    <= cnt_d;
      weight_q <= weight_d;
      shift_q  <= shift_d;
      theta_q  <= theta_d;
      refrac_q <= refrac_d;
      mode_q   <= mode_d;
    end
  end

  assign spike       = spike_q;
  assign u_out       = u_q;
  assign refractory  = (rcnt_q != '0);
  assign spike_count = cnt_q;

endmodule

// File: tb/tb_lif_neuron_cfg.sv
// Bench for lif_neuron_cfg: directed vector table, hand sequences for clamp
// and async reset, then random traffic against an integer reference model.
module tb_lif_neuron_cfg;

  logic       clk = 1'b0;
  logic       reset;
  logic       step;
  logic [3:0] x_in;
  logic       cfg_we;
  logic [3:0] cfg_addr;
  logic [7:0] cfg_data;
  logic       spike;
  logic [7:0] u_out;
  logic       refractory;
  logic [7:0] spike_count;

  int checks = 0;
  int errors = 0;

  lif_neuron_cfg #(
    .N_INPUTS(4), .U_WIDTH(8), .W_WIDTH(4), .REFRAC_WIDTH(3)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .step        (step),
    .x_in        (x_in),
    .cfg_we      (cfg_we),
    .cfg_addr    (cfg_addr),
    .cfg_data    (cfg_data),
    .spike       (spike),
    .u_out       (u_out),
    .refractory  (refractory),
    .spike_count (spike_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit we; int addr; int data; bit st; int x;
    int eu; bit es; bit er; int ec;
  } vec_t;

  vec_t tbl[24];

  // reference model state
  int m_u, m_rc, m_cnt, m_shift, m_theta, m_refrac, m_mode;
  int m_w[4];
  bit m_spike;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input int eu, input bit es, input bit er, input int ec);
    check({tag, " u_out"}, int'(u_out), eu);
    check({tag, " spike"}, int'(spike), int'(es));
    check({tag, " refractory"}, int'(refractory), int'(er));
    check({tag, " spike_count"}, int'(spike_count), ec);
  endtask

  task automatic apply(input bit we, input int addr, input int data, input bit st, input int x);
    cfg_we   = we;
    cfg_addr = 4'(addr);
    cfg_data = 8'(data);
    step     = st;
    x_in     = 4'(x);
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
    step   = 1'b0;
  endtask

  task automatic model_reset();
    m_u = 0; m_rc = 0; m_cnt = 0; m_spike = 0;
    m_shift = 1; m_theta = 5; m_refrac = 0; m_mode = 0;
    for (int i = 0; i < 4; i++) m_w[i] = 1;
  endtask

  task automatic model_clock(input bit we, input int addr, input int data, input bit st, input int x);
    int ul, sum;
    m_spike = 0;
    if (st) begin
      if (m_rc > 0) begin
        m_rc = m_rc - 1;
        m_u  = 0;
      end else begin
        ul  = (m_shift == 0) ? m_u : m_u - (m_u >> m_shift);
        sum = ul;
        for (int i = 0; i < 4; i++) if ((x >> i) & 1) sum += m_w[i];
        if (sum < 0) sum = 0;
        if (sum > 255) sum = 255;
        if (sum >= m_theta) begin
          m_spike = 1;
          m_u     = m_mode ? sum - m_theta : 0;
          m_rc    = m_refrac;
          m_cnt   = (m_cnt + 1) % 256;
        end else begin
          m_u = sum;
        end
      end
    end
    if (we) begin
      if (addr < 4) m_w[addr] = ((data & 15) >= 8) ? (data & 15) - 16 : (data & 15);
      else if (addr == 8)  m_shift  = data & 7;
      else if (addr == 9)  m_theta  = data & 255;
      else if (addr == 10) m_refrac = data & 7;
      else if (addr == 11) m_mode   = data & 1;
    end
  endtask

  initial begin
    // we, addr, data, step, x  |  u, spike, refractory, count
    tbl[0]  = '{0, 0, 0, 1, 'hF, 4, 0, 0, 0};
    tbl[1]  = '{0, 0, 0, 1, 'hF, 0, 1, 0, 1};
    tbl[2]  = '{0, 0, 0, 0, 'hF, 0, 0, 0, 1};
    tbl[3]  = '{1, 11, 1, 0, 0,   0, 0, 0, 1};
    tbl[4]  = '{0, 0, 0, 1, 'hF, 4, 0, 0, 1};
    tbl[5]  = '{0, 0, 0, 1, 'hF, 1, 1, 0, 2};
    tbl[6]  = '{1, 11, 'hFE, 0, 0, 1, 0, 0, 2};
    tbl[7]  = '{1, 10, 2, 0, 0,   1, 0, 0, 2};
    tbl[8]  = '{0, 0, 0, 1, 'hF, 0, 1, 1, 3};
    tbl[9]  = '{0, 0, 0, 1, 'hF, 0, 0, 1, 3};
    tbl[10] = '{0, 0, 0, 1, 'hF, 0, 0, 0, 3};
    tbl[11] = '{0, 0, 0, 1, 'hF, 4, 0, 0, 3};
    tbl[12] = '{0, 0, 0, 1, 'hF, 0, 1, 1, 4};
    tbl[13] = '{0, 0, 0, 0, 'hF, 0, 0, 1, 4};
    tbl[14] = '{1, 10, 0, 1, 'hF, 0, 0, 1, 4};
    tbl[15] = '{0, 0, 0, 1, 'hF, 0, 0, 0, 4};
    tbl[16] = '{1, 0, 8, 0, 0,    0, 0, 0, 4};
    tbl[17] = '{0, 0, 0, 1, 1,    0, 0, 0, 4};
    tbl[18] = '{1, 9, 3, 1, 'hE,  3, 0, 0, 4};
    tbl[19] = '{0, 0, 0, 1, 'hE,  0, 1, 0, 5};
    tbl[20] = '{1, 9, 0, 0, 0,    0, 0, 0, 5};
    tbl[21] = '{0, 0, 0, 1, 0,    0, 1, 0, 6};
    tbl[22] = '{1, 5, 'hFF, 0, 0, 0, 0, 0, 6};
    tbl[23] = '{0, 0, 0, 1, 1,    0, 1, 0, 7};

    reset = 1'b1; step = 1'b0; x_in = '0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 0, 0, 0, 0);
    reset = 1'b0;

    foreach (tbl[i]) begin
      apply(tbl[i].we, tbl[i].addr, tbl[i].data, tbl[i].st, tbl[i].x);
      check_all($sformatf("vec%0d", i), tbl[i].eu, tbl[i].es, tbl[i].er, tbl[i].ec);
    end

    // saturation: weights 7, no leak, theta 255
    reset = 1'b1; #2; reset = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) apply(1, i, 7, 0, 0);
    apply(1, 8, 0, 0, 0);
    apply(1, 9, 255, 0, 0);
    for (int k = 1; k <= 9; k++) begin
      apply(0, 0, 0, 1, 'hF);
      check_all($sformatf("ramp%0d", k), 28 * k, 0, 0, 0);
    end
    apply(0, 0, 0, 1, 'hF);
    check_all("clamp", 0, 1, 0, 1);
    apply(0, 0, 0, 1, 'hF);
    check_all("postclamp", 28, 0, 0, 1);

    // async reset between edges, then defaults restored
    #3 reset = 1'b1;
    #1;
    check_all("async_reset", 0, 0, 0, 0);
    @(posedge clk); #3 reset = 1'b0;
    @(posedge clk); #1;
    apply(0, 0, 0, 1, 'hF);
    check_all("after_reset1", 4, 0, 0, 0);
    apply(0, 0, 0, 1, 'hF);
    check_all("after_reset2", 0, 1, 0, 1);

    // random traffic against the model
    reset = 1'b1; #2; reset = 1'b0;
    @(posedge clk); #1;
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      bit we, st;
      int addr, data, x;
      we   = ($urandom % 4) == 0;
      addr = $urandom % 13;
      data = $urandom % 256;
      st   = ($urandom % 4) != 0;
      x    = $urandom % 16;
      apply(we, addr, data, st, x);
      model_clock(we, addr, data, st, x);
      check_all($sformatf("rand%0d", n), m_u, m_spike, m_rc != 0, m_cnt);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lif_neuron_cfg.md
Name: lif_neuron_cfg

Overview:
Parametrised successor to the single-input LIF neuron tile. Holds one leaky integrate-and-fire neuron with N_INPUTS binary synapses, per-synapse signed weights, programmable leak shift, threshold, refractory period and reset mode, all loaded over a register-write port. Integration advances only on a `step` strobe, so the top-level wrapper sets the timestep rate. Sits directly under the tile top, which drives `ui_in`/`uio_in` onto the `x_in` and `cfg_*` ports.

Parameters:
N_INPUTS, 4, number of binary synaptic inputs (1..8)
U_WIDTH, 8, membrane potential width, unsigned
W_WIDTH, 4, synaptic weight width, two's complement
REFRAC_WIDTH, 3, refractory counter width

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
step  input  1  timestep strobe; one integration per high cycle
x_in  input  N_INPUTS  binary input spikes, sampled when step=1
cfg_we  input  1  config write enable
cfg_addr  input  4  config register address
cfg_data  input  8  config write data
spike  output  1  registered spike pulse, 1 cycle
u_out  output  U_WIDTH  membrane potential register
refractory  output  1  high while the refractory counter is nonzero
spike_count  output  8  wrapping count of spikes since reset

Behaviour:
- Config map (write-only; unused data bits ignored; unmapped addresses ignored):
  - addr 0..N_INPUTS-1: weight[i] = cfg_data[W_WIDTH-1:0]
  - 8: shift = cfg_data[2:0]
  - 9: theta = cfg_data[U_WIDTH-1:0]
  - 10: refrac_len = cfg_data[REFRAC_WIDTH-1:0]
  - 11: reset_mode = cfg_data[0] (0 = reset-to-zero, 1 = subtract-theta)
- Reset (async, immediate): u_out=0, spike=0, refractory counter=0, spike_count=0, every weight=1, shift=1, theta=5, refrac_len=0, reset_mode=0.
- A config write takes effect the cycle after cfg_we. When cfg_we and step are high in the same cycle, step uses the old value.
- When step=0: u, counters and config are held, and spike=0 on the next cycle.
- When step=1 and the refractory counter is nonzero:
  - counter decrements; u_out forced to 0
  - no integration; spike=0
- When step=1 and the refractory counter is 0:
  - leak: shift=0 disables leak (ul=u); otherwise ul = u - (u >> shift), logical shift
  - sum = ul + Σ(x_in[i] ? sign-extended weight[i] : 0), computed signed at U_WIDTH+4 bits
  - clamp sum to [0, 2^U_WIDTH-1]
  - if clamped sum >= theta: spike=1 next cycle; u = 0 (mode 0) or clamped sum - theta (mode 1); counter loaded with refrac_len; spike_count increments (wraps 255 -> 0)
  - otherwise: u = clamped sum
- theta=0 makes the neuron spike on every non-refractory step. This is legal.
- Latency: step in cycle t updates u_out, spike and refractory at the cycle t+1 edge. spike stays high for exactly one cycle.
- reset asserted mid-operation discards in-flight state with no partial update. The first step after reset release is integrated normally.

Decomposition:
- Package lif_pkg holds:
  - config address constants: ADDR_SHIFT=8, ADDR_THETA=9, ADDR_REFRAC=10, ADDR_MODE=11
  - reset defaults: W_DEF=1, SHIFT_DEF=1, THETA_DEF=5
  - reset_mode enum: RST_ZERO, RST_SUB
- One combinational sub-module, lif_accumulate, computes leak, weighted sum and clamp, and emits clamped sum plus fire flag.
- Registers, refractory counter and config decode live in lif_neuron_cfg.

Test Plan:
- Defaults, x_in=4'b1111, step every cycle -> u_out 4, then spike=1 with u_out 0 on step 2 (leak 4-2=2, +4=6 >= 5); spike_count=1.
- refrac_len=2, same stimulus -> spike on step 2; steps 3-4 refractory=1, u_out 0; step 5 u=4; step 6 spike; spike_count=2.
- reset_mode=1, same stimulus -> step 2 spike=1, u_out=1 (6-5).
- All weights=7, shift=0, theta=255, x_in=1111 -> u_out rises by 28 each step to 252 at step 9; step 10 clamps 280 to 255, spike=1, u_out 0.
- weight[0]=4'h8 (-8), x_in=0001 from u=0 -> u_out stays 0 (low clamp), no spike. cfg write of theta=3 in the same cycle as a step -> that step still compares against 5.
- With u_out=4, assert reset between clock edges -> u_out=0, spike=0, spike_count=0 immediately; after release, defaults are restored and first step gives u_out=4.
